// File: rtl/seg7_scan_if.sv
// Display-side bundle between the 8-channel display multiplexer and the
// eight-digit scan driver. The board display pins are carried here too.
interface seg7_scan_if;
    logic        EN;
    logic [31:0] Disp_num;
    logic [7:0]  point_in;
    logic [7:0]  LE_in;
    logic [7:0]  AN;
    logic [7:0]  SEGMENT;
    logic        frame_done;

    modport master (
        output EN, Disp_num, point_in, LE_in,
        input  AN, SEGMENT, frame_done
    );

    modport slave (
        input  EN, Disp_num, point_in, LE_in,
        output AN, SEGMENT, frame_done
    );
endinterface

// File: rtl/seg7_scan.sv
// Eight-digit multiplexed common-anode seven-segment scan driver. The inputs
// are snapshotted once per frame so that the digits of one frame never tear.
module seg7_scan #(
    parameter int SCAN_DIV = 100000
) (
    input  logic        clk,
    input  logic        rst,
    seg7_scan_if.slave  bus
);
    localparam int CW = $clog2(SCAN_DIV);
    localparam logic [CW-1:0] CNT_MAX = CW'(SCAN_DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    idx_q, idx_d;
    logic [31:0]   sh_num_q, sh_num_d;
    logic [7:0]    sh_pt_q, sh_pt_d;
    logic [7:0]    sh_le_q, sh_le_d;
    logic [7:0]    an_q, an_d;
    logic [7:0]    seg_q, seg_d;
    logic          fd_q, fd_d;

    logic          capture;
    logic [31:0]   cur_num;
    logic [7:0]    cur_pt;
    logic [7:0]    cur_le;
    logic [3:0]    nib;

    function automatic logic [6:0] hex7(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

    always_comb begin
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        sh_num_d = sh_num_q;
        sh_pt_d  = sh_pt_q;
        sh_le_d  = sh_le_q;
        an_d     = 8'hFF;
        seg_d    = 8'hFF;
        fd_d     = 1'b0;
        capture  = 1'b0;
        cur_num  = sh_num_q;
        cur_pt   = sh_pt_q;
        cur_le   = sh_le_q;
        nib      = 4'h0;

        if (bus.EN) begin
            // The capture cycle decodes from the live inputs so digit 0 is
            // never shown from the previous frame's snapshot.
            capture = (cnt_q == '0) && (idx_q == 3'd0);
            if (capture) begin
                cur_num  = bus.Disp_num;
                cur_pt   = bus.point_in;
                cur_le   = bus.LE_in;
                sh_num_d = bus.Disp_num;
                sh_pt_d  = bus.point_in;
                sh_le_d  = bus.LE_in;
            end

            nib   = cur_num[{idx_q, 2'b00} +: 4];
            an_d  = ~(8'd1 << idx_q);
            seg_d = cur_le[idx_q] ? 8'hFF : {~cur_pt[idx_q], hex7(nib)};

            if (cnt_q == CNT_MAX) begin
                cnt_d = '0;
                idx_d = idx_q + 3'd1;
                fd_d  = (idx_q == 3'd7);
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q    <= '0;
            idx_q    <= 3'd0;
            sh_num_q <= 32'h0;
            sh_pt_q  <= 8'h0;
            sh_le_q  <= 8'h0;
            an_q     <= 8'hFF;
            seg_q    <= 8'hFF;
            fd_q     <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            sh_num_q <= sh_num_d;
            sh_pt_q  <= sh_pt_d;
            sh_le_q  <= sh_le_d;
            an_q     <= an_d;
            seg_q    <= seg_d;
            fd_q     <= fd_d;
        end
    end

    assign bus.AN         = an_q;
    assign bus.SEGMENT    = seg_q;
    assign bus.frame_done = fd_q;
endmodule

// File: tb/tb_seg7_scan.sv
// Bench for seg7_scan: frame-position reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_seg7_scan;
    localparam int SD    = 4;
    localparam int FRAME = 8 * SD;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   errors = 0;
    int   checks = 0;

    seg7_scan_if bus ();

    seg7_scan #(.SCAN_DIV(SD)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    logic [7:0] HEX [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                             8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

    // Reference model: position in the frame counted in enabled edges.
    int          m_pos = 0;
    int          m_dig;
    logic [31:0] m_num = 32'h0;
    logic [7:0]  m_pt  = 8'h0;
    logic [7:0]  m_le  = 8'h0;
    logic [7:0]  exp_an  = 8'hFF;
    logic [7:0]  exp_seg = 8'hFF;
    logic        exp_fd  = 1'b0;
    logic [3:0]  m_nib;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_pos = 0; m_num = 0; m_pt = 0; m_le = 0;
            exp_an = 8'hFF; exp_seg = 8'hFF; exp_fd = 1'b0;
        end else if (bus.EN) begin
            if (m_pos == 0) begin
                m_num = bus.Disp_num; m_pt = bus.point_in; m_le = bus.LE_in;
            end
            m_dig  = m_pos / SD;
            m_nib  = 4'((m_num >> (4 * m_dig)) & 32'hF);
            exp_an = 8'hFF ^ 8'(1 << m_dig);
            if (m_le[m_dig]) exp_seg = 8'hFF;
            else             exp_seg = {~m_pt[m_dig], HEX[m_nib][6:0]};
            exp_fd = (m_pos == FRAME - 1);
            m_pos  = (m_pos + 1) % FRAME;
        end else begin
            exp_an = 8'hFF; exp_seg = 8'hFF; exp_fd = 1'b0;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
        end
    endtask

    // Advance n edges, comparing the DUT to the model just after each one.
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            chk("model_an",  32'(bus.AN),         32'(exp_an));
            chk("model_seg", 32'(bus.SEGMENT),    32'(exp_seg));
            chk("model_fd",  32'(bus.frame_done), 32'(exp_fd));
        end
    endtask

    logic [7:0] an_tab   [8] = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hBF, 8'h7F};
    logic [7:0] scan_tab [8] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8};
    logic [7:0] hcov_tab [8] = '{8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

    initial begin
        bus.EN = 1'b1;
        bus.Disp_num = 32'h76543210;
        bus.point_in = 8'h00;
        bus.LE_in    = 8'h00;

        tick(2);
        chk("reset_an",  32'(bus.AN),         32'hFF);
        chk("reset_seg", 32'(bus.SEGMENT),    32'hFF);
        chk("reset_fd",  32'(bus.frame_done), 32'h0);
        @(negedge clk);
        rst = 1'b1;

        // Scan order; a mid-frame input change must not tear frame 1.
        for (int e = 0; e < FRAME; e++) begin
            tick(1);
            chk("scan_an",  32'(bus.AN),      32'(an_tab[e / SD]));
            chk("scan_seg", 32'(bus.SEGMENT), 32'(scan_tab[e / SD]));
            chk("scan_fd",  32'(bus.frame_done), (e == FRAME - 1) ? 32'h1 : 32'h0);
            if (e == 5) bus.Disp_num = 32'hFEDCBA98;
        end

        // Hex coverage; switch to all-F while digit 3 is lit.
        for (int e = 0; e < FRAME; e++) begin
            tick(1);
            if (e % SD == 0)
                chk("hexcov_seg", 32'(bus.SEGMENT), 32'(hcov_tab[e / SD]));
            if (e == 13) bus.Disp_num = 32'hFFFFFFFF;
        end

        tick(1);
        chk("capture_an",  32'(bus.AN),      32'hFE);
        chk("capture_seg", 32'(bus.SEGMENT), 32'h8E);
        bus.Disp_num = 32'h0;
        bus.point_in = 8'h01;
        bus.LE_in    = 8'h04;
        tick(FRAME - 1);

        // Decimal point and blanking.
        for (int e = 0; e < FRAME; e++) begin
            tick(1);
            if (e == 0)  chk("pt_seg0",    32'(bus.SEGMENT), 32'h40);
            if (e == 4)  chk("pt_seg1",    32'(bus.SEGMENT), 32'hC0);
            if (e == 8)  chk("blank_an2",  32'(bus.AN),      32'hFB);
            if (e == 8)  chk("blank_seg2", 32'(bus.SEGMENT), 32'hFF);
            if (e == 12) chk("pt_seg3",    32'(bus.SEGMENT), 32'hC0);
        end

        // Enable hold during digit 5 after two of its cycles.
        tick(5 * SD + 2);
        chk("hold_pre_an", 32'(bus.AN), 32'hDF);
        bus.EN = 1'b0;
        tick(1);
        chk("hold_off_an",  32'(bus.AN),      32'hFF);
        chk("hold_off_seg", 32'(bus.SEGMENT), 32'hFF);
        tick(9);
        bus.EN = 1'b1;
        tick(1);
        chk("resume_an_a", 32'(bus.AN), 32'hDF);
        tick(1);
        chk("resume_an_b", 32'(bus.AN), 32'hDF);
        tick(1);
        chk("resume_an_c", 32'(bus.AN), 32'hBF);

        // Reset mid-scan while digit 4 is lit.
        tick((SD - 1) + SD + 4 * SD + 1);
        chk("pre_rst_an", 32'(bus.AN), 32'hEF);
        #2;
        rst = 1'b0;
        #1;
        chk("rst_async_an",  32'(bus.AN),         32'hFF);
        chk("rst_async_seg", 32'(bus.SEGMENT),    32'hFF);
        chk("rst_async_fd",  32'(bus.frame_done), 32'h0);
        bus.Disp_num = 32'h89ABCDEF;
        bus.point_in = 8'h00;
        bus.LE_in    = 8'h00;
        tick(1);
        @(negedge clk);
        rst = 1'b1;
        tick(1);
        chk("restart_an",  32'(bus.AN),      32'hFE);
        chk("restart_seg", 32'(bus.SEGMENT), 32'h8E);

        // Randomized traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            tick(1);
            if ($urandom_range(0, 15) == 0) bus.Disp_num = $urandom();
            if ($urandom_range(0, 31) == 0) begin
                bus.point_in = 8'($urandom());
                bus.LE_in    = 8'($urandom()) & 8'($urandom());
            end
            if (bus.EN && $urandom_range(0, 39) == 0)       bus.EN = 1'b0;
            else if (!bus.EN && $urandom_range(0, 3) == 0)  bus.EN = 1'b1;
            if ($urandom_range(0, 499) == 0) begin
                #2;
                rst = 1'b0;
                #1;
                chk("rnd_rst_an",  32'(bus.AN),      32'hFF);
                chk("rnd_rst_seg", 32'(bus.SEGMENT), 32'hFF);
                tick(1);
                @(negedge clk);
                rst = 1'b1;
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
